// File: rtl/bus_unpack_pkg.sv
// Shared definitions for the bus packing / unpacking path: output FSM
// states, counter width and the field-order helpers for sig_bus = {sig_a, sig_b}.
package bus_unpack_pkg;

    localparam int unsigned COUNT_W     = 16;
    // Widest field the helpers can slice; callers zero-extend into this.
    localparam int unsigned MAX_FIELD_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_A,
        EMIT_B
    } unpack_state_e;

    function automatic logic [MAX_FIELD_W-1:0] low_mask(input int unsigned w);
        logic [MAX_FIELD_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_FIELD_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    // sig_a: upper field of a zero-extended packed word of field width w.
    function automatic logic [MAX_FIELD_W-1:0] field_a(input logic [2*MAX_FIELD_W-1:0] word,
                                                        input int unsigned w);
        return MAX_FIELD_W'(word >> w) & low_mask(w);
    endfunction

    // sig_b: lower field of a packed word of field width w.
    function automatic logic [MAX_FIELD_W-1:0] field_b(input logic [2*MAX_FIELD_W-1:0] word,
                                                        input int unsigned w);
        return MAX_FIELD_W'(word) & low_mask(w);
    endfunction

endpackage

// File: rtl/bus_unpacker_if.sv
// Packed-word input handshake and field-beat output stream of bus_unpacker.
interface bus_unpacker_if #(
    parameter int unsigned WIDTH = 8
);
    import bus_unpack_pkg::*;

    logic                 bus_valid;
    logic                 bus_ready;
    logic [2*WIDTH-1:0]   sig_bus;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_is_b;
    logic [COUNT_W-1:0]   word_count;

    modport slave (
        input  bus_valid, sig_bus, out_ready,
        output bus_ready, out_valid, out_data, out_is_b, word_count
    );

    modport master (
        output bus_valid, sig_bus, out_ready,
        input  bus_ready, out_valid, out_data, out_is_b, word_count
    );

endinterface

// File: rtl/unpack_fifo.sv
// Synchronous word FIFO with registered storage; head is the oldest entry.
// Caller guarantees no push when full and no pop when empty.
module unpack_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              one_left
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage write on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves occupancy unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign one_left = (count == CNT_W'(1));

endmodule

// File: rtl/bus_unpacker.sv
// Buffers packed {sig_a, sig_b} words and replays each as two field beats,
// sig_a first, on a single WIDTH-wide stream; counts fully emitted words.
module bus_unpacker
    import bus_unpack_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_unpacker_if.slave  bif
);
    unpack_state_e       state;
    unpack_state_e       state_n;
    logic [2*WIDTH-1:0]  head;
    logic                full;
    logic                empty;
    logic                one_left;
    logic                push;
    logic                pop;
    logic                ready_en;
    logic [COUNT_W-1:0]  word_cnt;

    assign push          = bif.bus_valid && bif.bus_ready;
    assign pop           = (state == EMIT_B) && bif.out_ready;
    assign bif.bus_ready = ready_en && !full;
    assign bif.word_count = word_cnt;

    unpack_fifo #(
        .DATA_W (2*WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wdata    (bif.sig_bus),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .one_left (one_left)
    );

    // Holds bus_ready low through reset and for the first cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state; a push coinciding with the last pop keeps the FSM in EMIT_A.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!empty) state_n = EMIT_A;
            EMIT_A:  if (bif.out_ready) state_n = EMIT_B;
            EMIT_B:  if (bif.out_ready) state_n = (!one_left || push) ? EMIT_A : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Beat outputs decoded from state and the FIFO head.
    always_comb begin
        bif.out_valid = 1'b0;
        bif.out_is_b  = 1'b0;
        bif.out_data  = '0;
        case (state)
            EMIT_A: begin
                bif.out_valid = 1'b1;
                bif.out_data  = WIDTH'(field_a((2*MAX_FIELD_W)'(head), WIDTH));
            end
            EMIT_B: begin
                bif.out_valid = 1'b1;
                bif.out_is_b  = 1'b1;
                bif.out_data  = WIDTH'(field_b((2*MAX_FIELD_W)'(head), WIDTH));
            end
            default: ;
        endcase
    end

    // Completed-word counter, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   word_cnt <= '0;
        else if (pop) word_cnt <= word_cnt + 1'b1;
    end

endmodule

// File: tb/tb_bus_unpacker.sv
// Self-checking bench for bus_unpacker: directed vector table, multi-cycle
// corner sequences and a randomized run against a queue-based reference model.
module tb_bus_unpacker;
    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bus_unpacker_if #(.WIDTH(W)) bif ();

    bus_unpacker #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        bv;
        logic [15:0] bus;
        logic        ordy;
        logic        ev;
        logic [7:0]  ed;
        logic        eb;
        logic        erdy;
        logic [15:0] ewc;
    } vec_t;

    typedef struct {
        logic [15:0] w;
        int          avail;
    } ent_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bif.bus_valid = 1'b0;
        bif.sig_bus   = '0;
        bif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_ready", 32'(bif.bus_ready), 32'd0);
        chk("rst_wc",    32'(bif.word_count), 32'd0);
        chk("rst_data",  32'(bif.out_data), 32'd0);
        chk("rst_is_b",  32'(bif.out_is_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_ready_after", 32'(bif.bus_ready), 32'd1);
    endtask

    function automatic vec_t mk(input logic bv, input logic [15:0] bus, input logic ordy,
                                input logic ev, input logic [7:0] ed, input logic eb,
                                input logic erdy, input logic [15:0] ewc);
        vec_t v;
        v.bv = bv; v.bus = bus; v.ordy = ordy;
        v.ev = ev; v.ed = ed; v.eb = eb; v.erdy = erdy; v.ewc = ewc;
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words [4];
        logic [7:0]  bd [8];
        logic        bb [8];
        int          beats, gap, idx;
        logic        took, mv, popped, rbv, rordy;
        logic [15:0] hw, wd;
        logic [7:0]  exp_d;
        ent_t        q[$];
        ent_t        e;
        logic        phase;
        int          cyc;
        int unsigned mwc;

        // Single word, backpressure, full FIFO. Expectations are after the edge.
        vecs.push_back(mk(1, 16'hA55A, 1,  0, 8'h00, 0, 1, 16'd0));
        vecs.push_back(mk(0, 16'h0000, 1,  1, 8'hA5, 0, 1, 16'd0));
        vecs.push_back(mk(0, 16'h0000, 1,  1, 8'h5A, 1, 1, 16'd0));
        vecs.push_back(mk(0, 16'h0000, 1,  0, 8'h00, 0, 1, 16'd1));
        vecs.push_back(mk(1, 16'h1234, 0,  0, 8'h00, 0, 1, 16'd1));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 16'h0000, 0,  1, 8'h12, 0, 1, 16'd1));
        vecs.push_back(mk(0, 16'h0000, 1,  1, 8'h34, 1, 1, 16'd1));
        vecs.push_back(mk(0, 16'h0000, 1,  0, 8'h00, 0, 1, 16'd2));
        vecs.push_back(mk(1, 16'h0102, 0,  0, 8'h00, 0, 1, 16'd2));
        vecs.push_back(mk(1, 16'h0304, 0,  1, 8'h01, 0, 0, 16'd2));
        vecs.push_back(mk(1, 16'h0506, 0,  1, 8'h01, 0, 0, 16'd2));
        vecs.push_back(mk(1, 16'h0506, 1,  1, 8'h02, 1, 0, 16'd2));
        vecs.push_back(mk(0, 16'h0000, 1,  1, 8'h03, 0, 1, 16'd3));
        vecs.push_back(mk(0, 16'h0000, 1,  1, 8'h04, 1, 1, 16'd3));
        vecs.push_back(mk(0, 16'h0000, 1,  0, 8'h00, 0, 1, 16'd4));

        do_reset();

        foreach (vecs[i]) begin
            bif.bus_valid = vecs[i].bv;
            bif.sig_bus   = vecs[i].bus;
            bif.out_ready = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bif.out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_ready", i), 32'(bif.bus_ready), 32'(vecs[i].erdy));
            chk($sformatf("vec%0d_wc", i),    32'(bif.word_count), 32'(vecs[i].ewc));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_data", i), 32'(bif.out_data), 32'(vecs[i].ed));
                chk($sformatf("vec%0d_is_b", i), 32'(bif.out_is_b), 32'(vecs[i].eb));
            end
        end

        // Reset while in EMIT_B with a second word queued.
        bif.bus_valid = 1'b1; bif.sig_bus = 16'h9C63; bif.out_ready = 1'b0;
        step();
        bif.sig_bus = 16'hAAAA;
        step();
        bif.bus_valid = 1'b0; bif.out_ready = 1'b1;
        step();
        chk("mid_pre_valid", 32'(bif.out_valid), 32'd1);
        chk("mid_pre_is_b",  32'(bif.out_is_b), 32'd1);
        bif.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bif.out_valid), 32'd0);
        chk("mid_rst_is_b",  32'(bif.out_is_b), 32'd0);
        chk("mid_rst_data",  32'(bif.out_data), 32'd0);
        chk("mid_rst_wc",    32'(bif.word_count), 32'd0);
        chk("mid_rst_ready", 32'(bif.bus_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mid_rel_ready", 32'(bif.bus_ready), 32'd1);
        chk("mid_rel_valid", 32'(bif.out_valid), 32'd0);
        step();
        chk("mid_empty_valid", 32'(bif.out_valid), 32'd0);
        bif.bus_valid = 1'b1; bif.sig_bus = 16'h4D2B; bif.out_ready = 1'b1;
        step();
        bif.bus_valid = 1'b0;
        step();
        chk("mid_new_a_valid", 32'(bif.out_valid), 32'd1);
        chk("mid_new_a_data",  32'(bif.out_data), 32'h4D);
        chk("mid_new_a_is_b",  32'(bif.out_is_b), 32'd0);
        step();
        chk("mid_new_b_data",  32'(bif.out_data), 32'h2B);
        chk("mid_new_b_is_b",  32'(bif.out_is_b), 32'd1);
        step();
        chk("mid_new_wc",      32'(bif.word_count), 32'd1);

        // Back-to-back stream of four words.
        do_reset();
        words[0] = 16'hC0DE; words[1] = 16'hBEEF; words[2] = 16'h1357; words[3] = 16'h2468;
        beats = 0; gap = 0; idx = 0;
        bif.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bif.out_valid) begin
                if (beats < 8) begin
                    bd[beats] = bif.out_data;
                    bb[beats] = bif.out_is_b;
                end
                beats++;
            end else if (beats > 0 && beats < 8) begin
                gap++;
            end
            if (beats >= 8) break;
            bif.bus_valid = (idx < 4);
            bif.sig_bus   = words[idx % 4];
            took = bif.bus_valid && bif.bus_ready;
            step();
            if (took) idx++;
        end
        bif.bus_valid = 1'b0;
        chk("b2b_beat_count", 32'(beats), 32'd8);
        chk("b2b_gaps", 32'(gap), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k < beats) begin
                hw = words[k / 2];
                exp_d = (k % 2 == 1) ? 8'(hw % 16'd256) : 8'(hw / 16'd256);
                chk($sformatf("b2b_data%0d", k), 32'(bd[k]), 32'(exp_d));
                chk($sformatf("b2b_is_b%0d", k), 32'(bb[k]), 32'(k % 2));
            end
        end
        step();
        chk("b2b_wc", 32'(bif.word_count), 32'd4);
        chk("b2b_idle", 32'(bif.out_valid), 32'd0);

        // word_count wrap: preload the counter, then complete one word.
        @(negedge clk);
        force dut.word_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.word_cnt;
        chk("wrap_preload", 32'(bif.word_count), 32'hFFFF);
        bif.bus_valid = 1'b1; bif.sig_bus = 16'h7E81; bif.out_ready = 1'b1;
        step();
        bif.bus_valid = 1'b0;
        step();
        step();
        chk("wrap_before_pop", 32'(bif.word_count), 32'hFFFF);
        step();
        chk("wrap_zero", 32'(bif.word_count), 32'd0);

        // Randomized run against a word-queue model.
        do_reset();
        q.delete();
        phase = 1'b0;
        cyc = 0;
        mwc = 0;
        for (int n = 0; n < 2000; n++) begin
            mv = (q.size() > 0) && (q[0].avail <= cyc);
            chk("rnd_valid", 32'(bif.out_valid), 32'(mv));
            if (mv) begin
                hw = q[0].w;
                exp_d = phase ? 8'(hw % 16'd256) : 8'(hw / 16'd256);
                chk("rnd_data", 32'(bif.out_data), 32'(exp_d));
                chk("rnd_is_b", 32'(bif.out_is_b), 32'(phase));
            end
            chk("rnd_ready", 32'(bif.bus_ready), 32'(q.size() < D));
            chk("rnd_wc", 32'(bif.word_count), mwc % 32'd65536);

            rbv   = ($urandom_range(0, 9) < 6);
            rordy = ($urandom_range(0, 9) < 7);
            wd    = 16'($urandom_range(0, 65535));
            bif.bus_valid = rbv;
            bif.sig_bus   = wd;
            bif.out_ready = rordy;
            took = rbv && (q.size() < D);
            step();
            cyc++;
            popped = 1'b0;
            if (mv && rordy) begin
                if (!phase) begin
                    phase = 1'b1;
                end else begin
                    void'(q.pop_front());
                    phase  = 1'b0;
                    mwc++;
                    popped = 1'b1;
                end
            end
            if (took) begin
                e.w     = wd;
                e.avail = (q.size() == 0 && !popped) ? cyc + 1 : cyc;
                q.push_back(e);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_unpacker.md
# bus_unpacker

Receive-side counterpart to the `{sig_a, sig_b}` bus-packing path. It accepts packed words `sig_bus = {sig_a, sig_b}` over a valid/ready handshake and buffers them in a small FIFO. Each word is emitted as two sequential field beats, `sig_a` first and then `sig_b`, on a single WIDTH-wide output stream. It sits downstream of any block that drives a concatenated `sig_bus` and feeds narrow per-field consumers.

## Interface
- `WIDTH`, default 8: width of each field; `sig_bus` is 2*WIDTH.
- `DEPTH`, default 2: FIFO entries (whole packed words). Must be ≥ 1 and a power of two.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `bus_valid`  input  1  packed word present.
- `bus_ready`  output  1  FIFO can accept a word.
- `sig_bus`  input  2*WIDTH  packed word; `[2*WIDTH-1:WIDTH]` = sig_a, `[WIDTH-1:0]` = sig_b.
- `out_valid`  output  1  field beat present.
- `out_ready`  input  1  downstream accepts the beat.
- `out_data`  output  WIDTH  field value.
- `out_is_b`  output  1  0 = beat carries sig_a, 1 = beat carries sig_b.
- `word_count`  output  16  count of fully emitted words (both beats accepted).

## Operation
- Input handshake: a word is pushed when `bus_valid && bus_ready`. `bus_ready = !full`.
  - There is no pass-through when full: a push and a pop in the same cycle while full does not occur, because `bus_ready` is already 0.
- FIFO: DEPTH entries with registered storage, plus pointers with one wrap bit or an occupancy counter.
  - Empty: occupancy 0. Full: occupancy DEPTH.
  - Pointers wrap modulo DEPTH.
- Output FSM, states IDLE, EMIT_A, EMIT_B:
  - IDLE: `out_valid=0`. Go to EMIT_A when the FIFO is non-empty.
  - EMIT_A: `out_valid=1`, `out_is_b=0`, `out_data` = head[2W-1:W]. On `out_ready`, go to EMIT_B.
  - EMIT_B: `out_valid=1`, `out_is_b=1`, `out_data` = head[W-1:0]. On `out_ready`:
    - pop the head;
    - increment `word_count`;
    - go to EMIT_A if the FIFO still holds another word after the pop, else IDLE.
- Simultaneous events:
  - A push in the same cycle as the EMIT_B pop is allowed whenever not full. The occupancy is unchanged.
  - If the FIFO was holding exactly one word, the newly pushed word becomes the head, and the FSM goes straight to EMIT_A in the next cycle with no IDLE bubble.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_is_b` hold their values. The head is not popped until the B beat is accepted.
- `word_count` wraps from 16'hFFFF to 0. It never saturates.
- Reset, asserted at any time including mid-word:
  - FIFO is emptied and the FSM goes to IDLE;
  - `out_valid=0`, `out_is_b=0`, `out_data=0`, `word_count=0`;
  - `bus_ready` goes to 1 one cycle after deassertion (0 while in reset).
  - A partially emitted word is discarded.

## Timing
- Minimum latency: a word pushed at edge N produces its A beat with `out_valid=1` after edge N+1, i.e. in the cycle following the push edge.
- Its B beat follows one cycle after A is accepted.
- Throughput: one field beat per cycle. Sustained input is one word per two cycles; `bus_ready` backpressures to enforce this.
- All outputs are driven from registers or FIFO storage, except `bus_ready`, which is decoded from occupancy registers only. There is no combinational path from `bus_valid` or `out_ready` to any output.

## Structure
- Shared package `bus_unpack_pkg` holds:
  - enum `unpack_state_e` {IDLE, EMIT_A, EMIT_B};
  - localparam `COUNT_W = 16`;
  - functions `field_a(word)` and `field_b(word)` for the bit slicing, so packer and unpacker agree on field order.
- Sub-module `unpack_fifo`: parameterised synchronous FIFO (DATA_W = 2*WIDTH, DEPTH) with push/pop/full/empty and head data. The FSM and counter stay in `bus_unpacker`.

## Test plan
- Single word: push `16'hA55A` with `out_ready=1` → beats `8'hA5` (`out_is_b=0`) then `8'h5A` (`out_is_b=1`) on consecutive cycles; `word_count` becomes 1.
- Backpressure: push `16'h1234`, hold `out_ready=0` for 5 cycles → `out_data=8'h12` stable, `out_valid=1`; release → `8'h12` then `8'h34`.
- Full FIFO (DEPTH=2): push `16'h0102`, `16'h0304` with `out_ready=0`, then assert `bus_valid` with a third word → `bus_ready=0`, third word not taken. After the first B beat is accepted → `bus_ready=1`.
- Back-to-back: stream 4 words with `out_ready=1` → 8 beats in order, no IDLE gap between words, `word_count=4`.
- Wrap: preload `word_count` to 16'hFFFF via 65535 words (or a force), emit one more word → `word_count=0`.
- Reset mid-word: assert `rst_n=0` while in EMIT_B → asynchronously `out_valid=0`, `word_count=0`, FIFO empty; after release the next pushed word emits A first.
